// File: rtl/model_temporal_link_controller_if.sv
// Bundle of the request, storage-fetch, result-stream and operator
// handshake signals of the temporal link matrix update sequencer.
interface model_temporal_link_controller_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_N_IN;
  logic [DATA_SIZE-1:0] INDEX_G_OUT;
  logic [DATA_SIZE-1:0] INDEX_J_OUT;
  logic [DATA_SIZE-1:0] W_G_IN;
  logic [DATA_SIZE-1:0] W_J_IN;
  logic [DATA_SIZE-1:0] P_J_IN;
  logic [DATA_SIZE-1:0] L_IN;
  logic [DATA_SIZE-1:0] L_OUT;
  logic                 L_OUT_ENABLE;
  logic [DATA_SIZE-1:0] L_OUT_G;
  logic [DATA_SIZE-1:0] L_OUT_J;
  logic                 ADD_START;
  logic                 ADD_READY;
  logic                 ADD_OPERATION;
  logic [DATA_SIZE-1:0] ADD_A;
  logic [DATA_SIZE-1:0] ADD_B;
  logic [DATA_SIZE-1:0] ADD_OUT;
  logic                 MUL_START;
  logic                 MUL_READY;
  logic [DATA_SIZE-1:0] MUL_A;
  logic [DATA_SIZE-1:0] MUL_B;
  logic [DATA_SIZE-1:0] MUL_OUT;

  // Controller side
  modport master (
    input  START, SIZE_N_IN, W_G_IN, W_J_IN, P_J_IN, L_IN,
    input  ADD_READY, ADD_OUT, MUL_READY, MUL_OUT,
    output READY, INDEX_G_OUT, INDEX_J_OUT,
    output L_OUT, L_OUT_ENABLE, L_OUT_G, L_OUT_J,
    output ADD_START, ADD_OPERATION, ADD_A, ADD_B,
    output MUL_START, MUL_A, MUL_B
  );

  // Environment side: requester, storage and the shared float units
  modport slave (
    output START, SIZE_N_IN, W_G_IN, W_J_IN, P_J_IN, L_IN,
    output ADD_READY, ADD_OUT, MUL_READY, MUL_OUT,
    input  READY, INDEX_G_OUT, INDEX_J_OUT,
    input  L_OUT, L_OUT_ENABLE, L_OUT_G, L_OUT_J,
    input  ADD_START, ADD_OPERATION, ADD_A, ADD_B,
    input  MUL_START, MUL_A, MUL_B
  );
endinterface

// File: rtl/model_temporal_link_controller.sv
// DNC temporal link matrix update sequencer:
//   L[g;j] = (1 - w[g] - w[j]) * L[g;j] + w[g] * p[j],  L[g;g] = 0
// Walks the matrix row-major and evaluates each off-diagonal element with
// a shared external float adder and multiplier, one operation at a time.
module model_temporal_link_controller #(
  parameter int                   DATA_SIZE    = 64,
  parameter int                   CONTROL_SIZE = 64,
  parameter logic [DATA_SIZE-1:0] ONE_FLOAT    = 64'h3FF0000000000000
) (
  input logic CLK,
  input logic RST,
  model_temporal_link_controller_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_SUB_G, ST_SUB_J, ST_MUL_L,
    ST_MUL_WP, ST_ADD_OUT, ST_WRITE, ST_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic                 phase_reg, phase_next;   // 0: issue start, 1: await ready
  logic [DATA_SIZE-1:0] n_reg, n_next;
  logic [DATA_SIZE-1:0] g_reg, g_next;
  logic [DATA_SIZE-1:0] j_reg, j_next;
  logic [DATA_SIZE-1:0] wg_reg, wg_next;
  logic [DATA_SIZE-1:0] wj_reg, wj_next;
  logic [DATA_SIZE-1:0] pj_reg, pj_next;
  logic [DATA_SIZE-1:0] l_reg, l_next;
  logic [DATA_SIZE-1:0] t_reg, t_next;           // chain t1 -> t2 -> t3
  logic [DATA_SIZE-1:0] wp_reg, wp_next;         // t4 = w[g] * p[j]
  logic [DATA_SIZE-1:0] result_reg, result_next;
  logic                 ready_reg, ready_next;
  logic [DATA_SIZE-1:0] lout_reg, lout_next;
  logic                 lout_en_reg, lout_en_next;
  logic [DATA_SIZE-1:0] lout_g_reg, lout_g_next;
  logic [DATA_SIZE-1:0] lout_j_reg, lout_j_next;

  logic                 add_start, add_op, mul_start;
  logic [DATA_SIZE-1:0] add_a, add_b, mul_a, mul_b;

  // State and datapath registers; reset aborts any update in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      phase_reg   <= 1'b0;
      n_reg       <= '0;
      g_reg       <= '0;
      j_reg       <= '0;
      wg_reg      <= '0;
      wj_reg      <= '0;
      pj_reg      <= '0;
      l_reg       <= '0;
      t_reg       <= '0;
      wp_reg      <= '0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
      lout_reg    <= '0;
      lout_en_reg <= 1'b0;
      lout_g_reg  <= '0;
      lout_j_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      n_reg       <= n_next;
      g_reg       <= g_next;
      j_reg       <= j_next;
      wg_reg      <= wg_next;
      wj_reg      <= wj_next;
      pj_reg      <= pj_next;
      l_reg       <= l_next;
      t_reg       <= t_next;
      wp_reg      <= wp_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
      lout_reg    <= lout_next;
      lout_en_reg <= lout_en_next;
      lout_g_reg  <= lout_g_next;
      lout_j_reg  <= lout_j_next;
    end
  end

  // Next-state, operator drive and index advance
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    n_next       = n_reg;
    g_next       = g_reg;
    j_next       = j_reg;
    wg_next      = wg_reg;
    wj_next      = wj_reg;
    pj_next      = pj_reg;
    l_next       = l_reg;
    t_next       = t_reg;
    wp_next      = wp_reg;
    result_next  = result_reg;
    ready_next   = 1'b0;
    lout_next    = lout_reg;
    lout_en_next = 1'b0;
    lout_g_next  = lout_g_reg;
    lout_j_next  = lout_j_reg;
    add_start    = 1'b0;
    add_op       = 1'b0;
    add_a        = '0;
    add_b        = '0;
    mul_start    = 1'b0;
    mul_a        = '0;
    mul_b        = '0;

    case (state_reg)
      ST_IDLE: begin
        // ready_reg is high only in the cycle right after DONE; a request
        // coinciding with that completion pulse is dropped
        if (bus.START && !ready_reg) begin
          n_next     = bus.SIZE_N_IN;
          g_next     = '0;
          j_next     = '0;
          phase_next = 1'b0;
          state_next = (bus.SIZE_N_IN == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        wg_next = bus.W_G_IN;
        wj_next = bus.W_J_IN;
        pj_next = bus.P_J_IN;
        l_next  = bus.L_IN;
        if (g_reg == j_reg) begin
          result_next = '0;
          state_next  = ST_WRITE;
        end else begin
          phase_next = 1'b0;
          state_next = ST_SUB_G;
        end
      end
      ST_SUB_G: begin
        add_op    = 1'b1;
        add_a     = ONE_FLOAT;
        add_b     = wg_reg;
        add_start = !phase_reg;
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bus.ADD_READY) begin
          t_next     = bus.ADD_OUT;
          phase_next = 1'b0;
          state_next = ST_SUB_J;
        end
      end
      ST_SUB_J: begin
        add_op    = 1'b1;
        add_a     = t_reg;
        add_b     = wj_reg;
        add_start = !phase_reg;
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bus.ADD_READY) begin
          t_next     = bus.ADD_OUT;
          phase_next = 1'b0;
          state_next = ST_MUL_L;
        end
      end
      ST_MUL_L: begin
        mul_a     = t_reg;
        mul_b     = l_reg;
        mul_start = !phase_reg;
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bus.MUL_READY) begin
          t_next     = bus.MUL_OUT;
          phase_next = 1'b0;
          state_next = ST_MUL_WP;
        end
      end
      ST_MUL_WP: begin
        mul_a     = wg_reg;
        mul_b     = pj_reg;
        mul_start = !phase_reg;
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bus.MUL_READY) begin
          wp_next    = bus.MUL_OUT;
          phase_next = 1'b0;
          state_next = ST_ADD_OUT;
        end
      end
      ST_ADD_OUT: begin
        add_op    = 1'b0;
        add_a     = t_reg;
        add_b     = wp_reg;
        add_start = !phase_reg;
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bus.ADD_READY) begin
          result_next = bus.ADD_OUT;
          phase_next  = 1'b0;
          state_next  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        lout_en_next = 1'b1;
        lout_next    = result_reg;
        lout_g_next  = g_reg;
        lout_j_next  = j_reg;
        if (j_reg != n_reg - 1'b1) begin
          j_next     = j_reg + 1'b1;
          state_next = ST_FETCH;
        end else if (g_reg != n_reg - 1'b1) begin
          j_next     = '0;
          g_next     = g_reg + 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.READY         = ready_reg;
  assign bus.INDEX_G_OUT   = g_reg;
  assign bus.INDEX_J_OUT   = j_reg;
  assign bus.L_OUT         = lout_reg;
  assign bus.L_OUT_ENABLE  = lout_en_reg;
  assign bus.L_OUT_G       = lout_g_reg;
  assign bus.L_OUT_J       = lout_j_reg;
  assign bus.ADD_START     = add_start;
  assign bus.ADD_OPERATION = add_op;
  assign bus.ADD_A         = add_a;
  assign bus.ADD_B         = add_b;
  assign bus.MUL_START     = mul_start;
  assign bus.MUL_A         = mul_a;
  assign bus.MUL_B         = mul_b;

endmodule

// File: tb/tb_model_temporal_link_controller.sv
// Bench for the temporal link matrix update sequencer: storage arrays,
// float adder/multiplier stubs with programmable latency, a strobe monitor
// and directed scenarios checked against hand-computed tables.
module tb_model_temporal_link_controller;
  localparam int DW = 64;
  localparam logic [63:0] F0   = 64'h0000000000000000;
  localparam logic [63:0] F025 = 64'h3FD0000000000000;
  localparam logic [63:0] F05  = 64'h3FE0000000000000;
  localparam logic [63:0] F1   = 64'h3FF0000000000000;

  typedef struct {
    int          g;
    int          j;
    logic [63:0] v;
    int          na;
    int          nm;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  model_temporal_link_controller_if #(.DATA_SIZE(DW)) bus ();

  model_temporal_link_controller #(
    .DATA_SIZE(DW), .CONTROL_SIZE(64), .ONE_FLOAT(64'h3FF0000000000000)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  // External storage, read combinationally by index
  logic [63:0] w_m [4];
  logic [63:0] p_m [4];
  logic [63:0] l_m [4][4];
  assign bus.W_G_IN = w_m[bus.INDEX_G_OUT[1:0]];
  assign bus.W_J_IN = w_m[bus.INDEX_J_OUT[1:0]];
  assign bus.P_J_IN = p_m[bus.INDEX_J_OUT[1:0]];
  assign bus.L_IN   = l_m[bus.INDEX_G_OUT[1:0]][bus.INDEX_J_OUT[1:0]];

  int tests = 0;
  int fails = 0;

  // Operator stubs
  int add_lat, mul_lat, add_left, mul_left, stab_err;
  bit add_busy, mul_busy, spur_en;
  logic [63:0] add_a_c, add_b_c, add_res, mul_a_c, mul_b_c, mul_res;
  logic add_op_c;

  initial begin
    add_busy = 0; mul_busy = 0; stab_err = 0;
  end

  // Float unit models; also flag any operand change while a result is pending
  always @(posedge CLK) begin
    bus.ADD_READY <= 1'b0;
    bus.MUL_READY <= 1'b0;
    if (RST) begin
      add_busy = 0;
      mul_busy = 0;
      bus.ADD_OUT <= '0;
      bus.MUL_OUT <= '0;
    end else begin
      if (add_busy) begin
        if (bus.ADD_A !== add_a_c || bus.ADD_B !== add_b_c || bus.ADD_OPERATION !== add_op_c)
          stab_err++;
        add_left--;
        if (add_left == 0) begin
          bus.ADD_READY <= 1'b1;
          bus.ADD_OUT   <= add_res;
          add_busy = 0;
        end
      end else if (bus.ADD_START) begin
        add_a_c  = bus.ADD_A;
        add_b_c  = bus.ADD_B;
        add_op_c = bus.ADD_OPERATION;
        add_res  = add_op_c ? $realtobits($bitstoreal(add_a_c) - $bitstoreal(add_b_c))
                            : $realtobits($bitstoreal(add_a_c) + $bitstoreal(add_b_c));
        if (add_lat <= 1) begin
          bus.ADD_READY <= 1'b1;
          bus.ADD_OUT   <= add_res;
        end else begin
          add_busy = 1;
          add_left = add_lat - 1;
        end
        if (spur_en && add_a_c == F1) begin
          bus.MUL_READY <= 1'b1;
          bus.MUL_OUT   <= 64'h7FF80000DEADBEEF;
        end
      end
      if (mul_busy) begin
        if (bus.MUL_A !== mul_a_c || bus.MUL_B !== mul_b_c) stab_err++;
        mul_left--;
        if (mul_left == 0) begin
          bus.MUL_READY <= 1'b1;
          bus.MUL_OUT   <= mul_res;
          mul_busy = 0;
        end
      end else if (bus.MUL_START) begin
        mul_a_c = bus.MUL_A;
        mul_b_c = bus.MUL_B;
        mul_res = $realtobits($bitstoreal(mul_a_c) * $bitstoreal(mul_b_c));
        if (mul_lat <= 1) begin
          bus.MUL_READY <= 1'b1;
          bus.MUL_OUT   <= mul_res;
        end else begin
          mul_busy = 1;
          mul_left = mul_lat - 1;
        end
      end
    end
  end

  // Strobe / pulse monitor
  vec_t sq[$];
  int add_el = 0, mul_el = 0, add_total = 0, mul_total = 0, ready_cnt = 0, overlap_cnt = 0;
  always @(negedge CLK) begin
    if (RST) begin
      add_el = 0;
      mul_el = 0;
    end else begin
      if (bus.ADD_START) begin add_el++; add_total++; end
      if (bus.MUL_START) begin mul_el++; mul_total++; end
      if (bus.ADD_START && bus.MUL_START) overlap_cnt++;
      if (bus.READY) ready_cnt++;
      if (bus.L_OUT_ENABLE) begin
        sq.push_back('{int'(bus.L_OUT_G), int'(bus.L_OUT_J), bus.L_OUT, add_el, mul_el});
        add_el = 0;
        mul_el = 0;
      end
    end
  end

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic start_pulse(input logic [63:0] n);
    bus.START     = 1'b1;
    bus.SIZE_N_IN = n;
    step(1);
    bus.START     = 1'b0;
  endtask

  task automatic wait_ready(input int base, input int budget, input string nm);
    int k = 0;
    while (ready_cnt == base && k < budget) begin
      step(1);
      k++;
    end
    check64(nm, 64'(ready_cnt != base), 64'd1);
  endtask

  task automatic check_zero(input string nm);
    check64({nm, "_flags"}, {60'd0, bus.READY, bus.L_OUT_ENABLE, bus.ADD_START, bus.MUL_START}, 64'd0);
    check64({nm, "_l_out"}, bus.L_OUT, 64'd0);
    check64({nm, "_tags"}, bus.L_OUT_G | bus.L_OUT_J, 64'd0);
    check64({nm, "_index"}, bus.INDEX_G_OUT | bus.INDEX_J_OUT, 64'd0);
    check64({nm, "_operands"}, bus.ADD_A | bus.ADD_B | bus.MUL_A | bus.MUL_B, 64'd0);
  endtask

  vec_t exp_q[$];

  // Compare the strobes captured since 'base' against exp_q
  task automatic check_strobes(input int base, input string nm);
    check64({nm, "_count"}, 64'(sq.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < sq.size()) begin
        check64($sformatf("%s_tag%0d", nm, i), {32'(sq[base+i].g), 32'(sq[base+i].j)},
                {32'(exp_q[i].g), 32'(exp_q[i].j)});
        check64($sformatf("%s_val%0d", nm, i), sq[base+i].v, exp_q[i].v);
        check64($sformatf("%s_ops%0d", nm, i), {32'(sq[base+i].na), 32'(sq[base+i].nm)},
                {32'(exp_q[i].na), 32'(exp_q[i].nm)});
      end
    end
  endtask

  task automatic load_s1();
    w_m[0] = F025; w_m[1] = F05;
    p_m[0] = F05;  p_m[1] = F025;
    l_m[0][0] = F0;  l_m[0][1] = F1;
    l_m[1][0] = F05; l_m[1][1] = F0;
    exp_q.delete();
    exp_q.push_back('{0, 0, 64'h0000000000000000, 0, 0});
    exp_q.push_back('{0, 1, 64'h3FD4000000000000, 3, 2});
    exp_q.push_back('{1, 0, 64'h3FD8000000000000, 3, 2});
    exp_q.push_back('{1, 1, 64'h0000000000000000, 0, 0});
  endtask

  function automatic logic [63:0] ref_val(input int g, input int j);
    real wg, wj, pj, l;
    if (g == j) return 64'd0;
    wg = $bitstoreal(w_m[g]);
    wj = $bitstoreal(w_m[j]);
    pj = $bitstoreal(p_m[j]);
    l  = $bitstoreal(l_m[g][j]);
    return $realtobits((1.0 - wg - wj) * l + wg * pj);
  endfunction

  // Single-update scenario: pulse START, wait, verify strobes and one READY
  task automatic run_s1(input string nm);
    int base, rb, ov, se;
    base = sq.size(); rb = ready_cnt; ov = overlap_cnt; se = stab_err;
    start_pulse(64'd2);
    wait_ready(rb, 600, {nm, "_ready_timeout"});
    step(6);
    check_strobes(base, nm);
    check64({nm, "_ready_pulses"}, 64'(ready_cnt - rb), 64'd1);
    check64({nm, "_overlap"}, 64'(overlap_cnt - ov), 64'd0);
    check64({nm, "_operand_stable"}, 64'(stab_err - se), 64'd0);
  endtask

  initial begin
    int base, rb, at, mt, k;
    RST = 1'b1;
    bus.START = 1'b0;
    bus.SIZE_N_IN = '0;
    add_lat = 2; mul_lat = 3; spur_en = 0;
    for (int a = 0; a < 4; a++) begin
      w_m[a] = F0; p_m[a] = F0;
      for (int b = 0; b < 4; b++) l_m[a][b] = F0;
    end
    load_s1();
    step(3);
    check_zero("reset");
    RST = 1'b0;
    step(2);

    // Basic 2x2 update
    run_s1("s1");

    // N = 0: READY two cycles after START, nothing else; START on READY ignored
    base = sq.size(); rb = ready_cnt; at = add_total; mt = mul_total;
    start_pulse(64'd0);
    check64("n0_ready_cycle1", {63'd0, bus.READY}, 64'd0);
    step(1);
    check64("n0_ready_cycle2", {63'd0, bus.READY}, 64'd1);
    start_pulse(64'd0);
    check64("n0_ready_after", {63'd0, bus.READY}, 64'd0);
    step(6);
    check64("n0_ready_pulses", 64'(ready_cnt - rb), 64'd1);
    check64("n0_strobes", 64'(sq.size() - base), 64'd0);
    check64("n0_ops", 64'((add_total - at) + (mul_total - mt)), 64'd0);

    // N = 3 with nonzero diagonal inputs
    w_m[0] = 64'h3FC0000000000000; w_m[1] = F025; w_m[2] = 64'h3FB0000000000000;
    p_m[0] = F05; p_m[1] = F025; p_m[2] = 64'h3FE8000000000000;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        l_m[a][b] = $realtobits(0.5 * real'(a + b + 1));
    exp_q.delete();
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        exp_q.push_back('{a, b, ref_val(a, b), (a == b) ? 0 : 3, (a == b) ? 0 : 2});
    base = sq.size(); rb = ready_cnt;
    start_pulse(64'd3);
    wait_ready(rb, 1500, "n3_ready_timeout");
    step(4);
    check_strobes(base, "n3");

    // Latency extremes with a spurious multiplier READY during SUB_G
    load_s1();
    add_lat = 1; mul_lat = 7; spur_en = 1;
    run_s1("lat_1_7");
    add_lat = 7; mul_lat = 1;
    run_s1("lat_7_1");
    spur_en = 0;

    // Reset while (0,1) waits in MUL_L, then a clean rerun
    add_lat = 2; mul_lat = 7;
    rb = ready_cnt; mt = mul_total; k = 0;
    start_pulse(64'd2);
    while (mul_total == mt && k < 300) begin
      step(1);
      k++;
    end
    check64("abort_reach_mul_l", 64'(mul_total != mt), 64'd1);
    step(2);
    #2 RST = 1'b1;
    #1 check_zero("abort");
    step(2);
    RST = 1'b0;
    step(10);
    check64("abort_no_ready", 64'(ready_cnt - rb), 64'd0);
    run_s1("after_abort");

    // START held for 20 cycles: exactly one update
    add_lat = 2; mul_lat = 3;
    base = sq.size(); rb = ready_cnt;
    bus.SIZE_N_IN = 64'd2;
    bus.START = 1'b1;
    step(20);
    bus.START = 1'b0;
    wait_ready(rb, 600, "held_ready_timeout");
    step(30);
    check_strobes(base, "held");
    check64("held_ready_pulses", 64'(ready_cnt - rb), 64'd1);
    check64("total_overlap", 64'(overlap_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/model_temporal_link_controller.md
Name: model_temporal_link_controller

Overview:
- Sequencer that computes one update of the DNC temporal link matrix, element by element, in row-major order: L(t)[g;j] = (1 - w[g] - w[j])·L(t-1)[g;j] + w[g]·p[j], with L(t)[g;g] = 0.
- Drives one shared scalar float adder and one shared scalar float multiplier, both instantiated outside this block, through START/READY handshakes.
- Fetches operands by index from external vector/matrix storage and streams results out with index tags.

Parameters:
- DATA_SIZE, 64, width of data words, indices and float operands (IEEE-754 binary64 at default).
- CONTROL_SIZE, 64, reserved for codebase-wide consistency; no function in this block.
- ONE_FLOAT, 64'h3FF0000000000000, encoding of the float constant 1.0.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  one-cycle request to begin a matrix update.
- READY  out  1  one-cycle pulse when the full update is complete.
- SIZE_N_IN  in  DATA_SIZE  matrix dimension N; sampled on accepted START.
- INDEX_G_OUT  out  DATA_SIZE  current row index g.
- INDEX_J_OUT  out  DATA_SIZE  current column index j.
- W_G_IN  in  DATA_SIZE  w[g] for the current g (combinational external read).
- W_J_IN  in  DATA_SIZE  w[j] for the current j.
- P_J_IN  in  DATA_SIZE  p(t-1)[j].
- L_IN  in  DATA_SIZE  L(t-1)[g;j].
- L_OUT  out  DATA_SIZE  updated element.
- L_OUT_ENABLE  out  1  L_OUT valid strobe, one cycle per element.
- L_OUT_G  out  DATA_SIZE  row index of L_OUT.
- L_OUT_J  out  DATA_SIZE  column index of L_OUT.
- ADD_START  out  1  adder start pulse.
- ADD_READY  in  1  adder done pulse.
- ADD_OPERATION  out  1  0 = A+B, 1 = A−B.
- ADD_A, ADD_B  out  DATA_SIZE  adder operands.
- ADD_OUT  in  DATA_SIZE  adder result.
- MUL_START  out  1  multiplier start pulse.
- MUL_READY  in  1  multiplier done pulse.
- MUL_A, MUL_B  out  DATA_SIZE  multiplier operands.
- MUL_OUT  in  DATA_SIZE  multiplier result.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; g = j = 0; internal temporaries cleared. Reset asserted mid-operation aborts the update immediately. No READY is produced for the aborted update. Operator pulses are not reissued.
- States: IDLE, FETCH, SUB_G, SUB_J, MUL_L, MUL_WP, ADD_OUT, WRITE, DONE.
- IDLE:
  - START = 1 latches N and sets g = j = 0.
  - Next state is DONE if N == 0, otherwise FETCH.
  - START is ignored in every state other than IDLE.
- FETCH: registers W_G_IN, W_J_IN, P_J_IN and L_IN. INDEX_G_OUT/INDEX_J_OUT are stable at least one full cycle before this sample.
  - g == j: result = 0, go to WRITE; no operator is used.
  - Otherwise go to SUB_G.
- Operation states each have two phases:
  - Phase 0: assert the unit's START for exactly one cycle with operands.
  - Phase 1: hold operands stable and wait for that unit's READY; capture its result on READY, then advance.
  - Unit latency is arbitrary, at least 1 cycle.
- Operation sequence:
  - SUB_G: t1 = ONE_FLOAT − w[g] (ADD_OPERATION = 1).
  - SUB_J: t2 = t1 − w[j] (ADD_OPERATION = 1).
  - MUL_L: t3 = t2 · L.
  - MUL_WP: t4 = w[g] · p[j].
  - ADD_OUT: result = t3 + t4 (ADD_OPERATION = 0).
- Never more than one outstanding operation; ADD_START and MUL_START are never high in the same cycle.
- A READY from the unit not currently awaited is ignored.
- WRITE: for one cycle, L_OUT_ENABLE = 1, L_OUT = result, L_OUT_G = g, L_OUT_J = j. L_OUT and the tags hold their values after the strobe drops. Index advance:
  - j < N−1: j++, go to FETCH.
  - j == N−1 and g < N−1: j = 0, g++, go to FETCH.
  - j == N−1 and g == N−1: go to DONE.
- DONE: READY = 1 for one cycle, then IDLE.
- START arriving on the cycle READY is high is ignored; the first acceptance is the following cycle, in IDLE.
- Index arithmetic is unsigned DATA_SIZE; N up to 2^DATA_SIZE−1, no wrap detection.
- Exactly N² L_OUT_ENABLE strobes per update, in strictly row-major order.

Test Plan:
- N=2, w=[0.25,0.5], p=[0.5,0.25], L=[[0,1.0],[0.5,0]] -> strobes (0,0)=0, (0,1)=0x3FD4000000000000 (0.3125), (1,0)=0x3FD8000000000000 (0.375), (1,1)=0; then a single READY pulse.
- N=0 START -> no L_OUT_ENABLE and no operator START; READY pulses exactly 2 cycles after START.
- N=3, all diagonals: check zero output on (0,0), (1,1), (2,2) with no ADD_START/MUL_START issued for them; 6 off-diagonal elements each issue exactly 3 ADD_START and 2 MUL_START.
- Operator stubs with latencies 1 and 7 plus spurious MUL_READY during SUB_G -> results identical to the first scenario; spurious pulse ignored; operands stable until READY.
- RST pulsed during MUL_L of element (0,1), then START with N=2 -> all outputs 0 after reset; the fresh run reproduces the first scenario exactly; no READY from the aborted run.
- START held high for 20 cycles during a run -> only one update performed; exactly 4 strobes.
